cla_seq_adder: RTL and testbench

Parametrised multi-cycle carry-lookahead adder/subtractor, successor to the fixed 16-bit combinational CLA. It processes a WIDTH-bit operation in BLOCK-bit slices, one slice per clock, through a single BLOCK-bit lookahead slice built from 4-bit CLA groups. The carry is registered between slices. Operands are accepted with a start/done handshake, and the block adds subtract mode and a signed-overflow flag.

---
 rtl/cla_seq_adder_if.sv | 26 ++
 rtl/cla_seq_adder.sv | 132 +++++++++++++
 tb/tb_cla_seq_adder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
// The master issues start with operands; the slave returns busy/done and the registered result.
interface cla_seq_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, in_a, in_b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, in_a, in_b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: one BLOCK-bit slice per clock,
// built from 4-bit lookahead groups, with the inter-slice carry held in a register.
module cla_seq_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_seq_adder_if.slave  bus
);
  localparam int N      = WIDTH / BLOCK;
  localparam int GROUPS = BLOCK / 4;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, sum_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;

  logic [BLOCK-1:0] sa, sb, gen, prop, slice_sum;
  logic [BLOCK-1:0] bit_c;
  logic [GROUPS-1:0] grp_g, grp_p;
  logic [GROUPS:0]  grp_c;
  logic [WIDTH-1:0] work_next;
  logic             slice_cout, slice_cmsb, last, accept;

  // Carry into position n in sum-of-products form: every carry is a flat
  // function of the generates, propagates and c0, never of a previous carry.
  function automatic logic la_carry(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p,
                                    input logic c0, input int n);
    logic res, term;
    res = c0;
    for (int k = 0; k < BLOCK; k++)
      if (k < n) res = res & p[k];
    for (int k = 0; k < BLOCK; k++) begin
      if (k < n) begin
        term = g[k];
        for (int m = 0; m < BLOCK; m++)
          if (m > k && m < n) term = term & p[m];
        res = res | term;
      end
    end
    return res;
  endfunction

  // NOTE: every always_comb output is assigned before any conditional use so no latch is inferred.
  always_comb begin
    sa    = a_q[cnt_q*BLOCK +: BLOCK];
    sb    = b_q[cnt_q*BLOCK +: BLOCK];
    gen   = sa & sb;
    prop  = sa ^ sb;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    bit_c = '0;
    for (int g = 0; g < GROUPS; g++) begin
      grp_g[g] = la_carry(BLOCK'(gen[4*g +: 4]), BLOCK'(prop[4*g +: 4]), 1'b0, 4);
      grp_p[g] = &prop[4*g +: 4];
    end
    for (int j = 0; j <= GROUPS; j++)
      grp_c[j] = la_carry(BLOCK'(grp_g), BLOCK'(grp_p), carry_q, j);
    for (int g = 0; g < GROUPS; g++)
      for (int i = 0; i < 4; i++)
        bit_c[4*g+i] = la_carry(BLOCK'(gen[4*g +: 4]), BLOCK'(prop[4*g +: 4]), grp_c[g], i);
    slice_sum  = prop ^ bit_c;
    slice_cout = grp_c[GROUPS];
    slice_cmsb = bit_c[BLOCK-1];
    work_next  = work_q;
    work_next[cnt_q*BLOCK +: BLOCK] = slice_sum;
  end

  assign last   = (cnt_q == CNT_W'(N - 1));
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath work registers are cleared too, so an aborted operation leaves no residue.
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: done_q <= 1'b0;
        RUN: begin
          work_q  <= work_next;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last) begin
            sum_q   <= work_next;
            cout_q  <= slice_cout;
            ovf_q   <= slice_cmsb ^ slice_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Subtraction is folded into the operands here: A + ~B + ~borrow.
      if (accept) begin
        a_q     <= bus.in_a;
        b_q     <= bus.sub ? ~bus.in_b : bus.in_b;
        carry_q <= bus.cin ^ bus.sub;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= RUN;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed cases at 32/8, reset abort,
// handshake corners, then random sweeps at 16/4 and 32/32 against an arithmetic model.
module tb_cla_seq_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cla_seq_adder_if #(.WIDTH(32)) bus_a ();
  cla_seq_adder_if #(.WIDTH(16)) bus_b ();
  cla_seq_adder_if #(.WIDTH(32)) bus_c ();

  cla_seq_adder #(.WIDTH(32), .BLOCK(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  cla_seq_adder #(.WIDTH(16), .BLOCK(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  cla_seq_adder #(.WIDTH(32), .BLOCK(32)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain w-bit two's-complement arithmetic.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic ci, input logic sb,
                                output logic [31:0] s, output logic co, output logic ov);
    longint unsigned mask, aa, bb, full;
    mask = (64'd1 << w) - 1;
    aa   = 64'(a) & mask;
    bb   = sb ? (~64'(b) & mask) : (64'(b) & mask);
    full = aa + bb + 64'(ci ^ sb);
    s    = 32'(full & mask);
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
  endfunction

  task automatic op_a(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                      output int edges, output int busy_cnt);
    @(negedge clk);
    bus_a.in_a = a; bus_a.in_b = b; bus_a.cin = ci; bus_a.sub = sb; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    edges = 0; busy_cnt = 0;
    while (!bus_a.done && edges < 50) begin
      busy_cnt += int'(bus_a.busy);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic op_b(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                      output int edges);
    @(negedge clk);
    bus_b.in_a = a[15:0]; bus_b.in_b = b[15:0]; bus_b.cin = ci; bus_b.sub = sb; bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    edges = 0;
    while (!bus_b.done && edges < 50) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic op_c(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                      output int edges);
    @(negedge clk);
    bus_c.in_a = a; bus_c.in_b = b; bus_c.cin = ci; bus_c.sub = sb; bus_c.start = 1'b1;
    @(negedge clk);
    bus_c.start = 1'b0;
    edges = 0;
    while (!bus_c.done && edges < 50) begin
      @(negedge clk);
      edges++;
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a, b;
    logic        ci, sb;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;

  vec_t dir[6] = '{
    '{"basic_add", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0},
    '{"full_carry", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{"signed_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{"sub_5_7", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{"sub_min_1", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1},
    '{"sub_borrow", 32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0}
  };

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFFFFFF;
      1:       return 32'h0;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          edges, busy_cnt, k, done_cnt, hold_bad;
    logic [31:0] s, ra, rb;
    logic        co, ov, rci, rsb;

    {bus_a.start, bus_a.in_a, bus_a.in_b, bus_a.cin, bus_a.sub} = '0;
    {bus_b.start, bus_b.in_a, bus_b.in_b, bus_b.cin, bus_b.sub} = '0;
    {bus_c.start, bus_c.in_a, bus_c.in_b, bus_c.cin, bus_c.sub} = '0;

    #12;
    check("reset_outputs", {bus_a.sum, bus_a.cout, bus_a.ovf, bus_a.busy, bus_a.done}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir[i]) begin
      op_a(dir[i].a, dir[i].b, dir[i].ci, dir[i].sb, edges, busy_cnt);
      check({dir[i].tag, "_latency"}, 64'(edges), 64'd4);
      check({dir[i].tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
      check({dir[i].tag, "_sum"}, 64'(bus_a.sum), 64'(dir[i].s));
      check({dir[i].tag, "_cout_ovf"}, {bus_a.cout, bus_a.ovf}, {dir[i].co, dir[i].ov});
      check({dir[i].tag, "_busy_at_done"}, 64'(bus_a.busy), 64'd0);
      @(negedge clk);
      check({dir[i].tag, "_done_one_cycle"}, 64'(bus_a.done), 64'd0);
    end

    // A start pulse in the middle of RUN must not disturb the operation.
    @(negedge clk);
    bus_a.in_a = 32'd3; bus_a.in_b = 32'd4; bus_a.cin = 1'b0; bus_a.sub = 1'b0; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    @(negedge clk);
    bus_a.in_a = 32'h100; bus_a.in_b = 32'h200; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    edges = 2;
    while (!bus_a.done && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    check("run_start_latency", 64'(edges), 64'd4);
    check("run_start_sum", 64'(bus_a.sum), 64'd7);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      done_cnt += int'(bus_a.done);
    end
    check("run_start_no_extra_done", 64'(done_cnt), 64'd0);

    // Back-to-back: start held through the DONE cycle launches the second operation.
    @(negedge clk);
    bus_a.in_a = 32'h12345678; bus_a.in_b = 32'h11111111; bus_a.cin = 1'b0; bus_a.sub = 1'b0;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.in_a = 32'h10; bus_a.in_b = 32'h1; bus_a.sub = 1'b1;
    edges = 0;
    while (!bus_a.done && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    check("b2b_first_latency", 64'(edges), 64'd4);
    check("b2b_first_sum", 64'(bus_a.sum), 64'h23456789);
    k = 0; hold_bad = 0;
    do begin
      @(negedge clk);
      bus_a.start = 1'b0;
      k++;
      if (!bus_a.done && bus_a.sum !== 32'h23456789) hold_bad++;
    end while (!bus_a.done && k < 50);
    check("b2b_done_spacing", 64'(k), 64'd5);
    check("b2b_sum_held", 64'(hold_bad), 64'd0);
    check("b2b_second_result", {bus_a.cout, bus_a.ovf, bus_a.sum}, {1'b1, 1'b0, 32'h0000000F});

    // Reset in the middle of RUN clears everything at once and yields no done.
    op_a(32'h80000000, 32'h1, 1'b0, 1'b1, edges, busy_cnt);
    check("pre_reset_result", {bus_a.cout, bus_a.ovf, bus_a.sum}, {1'b1, 1'b1, 32'h7FFFFFFF});
    @(negedge clk);
    bus_a.in_a = 32'h1; bus_a.in_b = 32'h1; bus_a.sub = 1'b0; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sum", 64'(bus_a.sum), 64'd0);
    check("abort_flags", {bus_a.cout, bus_a.ovf, bus_a.busy, bus_a.done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      done_cnt += int'(bus_a.done);
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = rand_operand(); rb = rand_operand();
      rci = 1'($urandom); rsb = 1'($urandom);
      model(16, ra, rb, rci, rsb, s, co, ov);
      op_b(ra, rb, rci, rsb, edges);
      check("w16_latency", 64'(edges), 64'd4);
      check("w16_cout_sum", {bus_b.cout, bus_b.sum}, {co, s[15:0]});
      check("w16_ovf", 64'(bus_b.ovf), 64'(ov));
    end

    for (int i = 0; i < 1000; i++) begin
      ra = rand_operand(); rb = rand_operand();
      rci = 1'($urandom); rsb = 1'($urandom);
      model(32, ra, rb, rci, rsb, s, co, ov);
      op_c(ra, rb, rci, rsb, edges);
      check("w32b32_latency", 64'(edges), 64'd1);
      check("w32b32_cout_sum", {bus_c.cout, bus_c.sum}, {co, s});
      check("w32b32_ovf", 64'(bus_c.ovf), 64'(ov));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
